// File: rtl/pixel_scheduler.sv
// pixel_scheduler: round-robin (x,y) dispatch to N_ENGINES depth engines, results re-serialised in raster order.
// Define PIXEL_SCHED_PERF_EN to add per-frame perf_frame_cycles / perf_stall_cycles outputs.
module pixel_scheduler #(
  parameter int N_ENGINES = 4,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int DEPTH_W   = 8
) (
  input  logic                         out_stream_aclk,
  input  logic                         periph_resetn,
  input  logic                         run,
  output logic [N_ENGINES-1:0]         eng_start,
  output logic [9:0]                   eng_x,
  output logic [8:0]                   eng_y,
  input  logic [N_ENGINES-1:0]         eng_done,
  input  logic [N_ENGINES*DEPTH_W-1:0] eng_depth,
  output logic [DEPTH_W-1:0]           pix_depth,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic                         pix_sof,
  output logic                         pix_eol,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         err
`ifdef PIXEL_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_frame_cycles,
  output logic [31:0]                  perf_stall_cycles
`endif
);
  localparam int PW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(N_ENGINES - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} slot_t;
  slot_t                r_st     [N_ENGINES];
  slot_t                w_st_nxt [N_ENGINES];
  logic [DEPTH_W-1:0]   r_depth  [N_ENGINES];
  logic [N_ENGINES-1:0] r_sof, r_eol, r_last, r_eng_start, w_cap;
  logic [PW-1:0]        r_dp, r_op;
  logic [9:0]           r_x, r_eng_x;
  logic [8:0]           r_y, r_eng_y;
  logic                 r_frame_done, r_err;
  logic                 w_disp, w_acc, w_xl, w_yl, w_busy, w_err;

  assign w_disp     = run && (r_st[r_dp] == IDLE);
  assign pix_valid  = r_st[r_op] == DONE;
  assign w_acc      = pix_valid && pix_ready;
  assign w_xl       = r_x == 10'(X_SIZE - 1);
  assign w_yl       = r_y == 9'(Y_SIZE - 1);
  assign pix_depth  = r_depth[r_op];
  assign pix_sof    = pix_valid && r_sof[r_op];
  assign pix_eol    = pix_valid && r_eol[r_op];
  assign eng_start  = r_eng_start;
  assign eng_x      = r_eng_x;
  assign eng_y      = r_eng_y;
  assign frame_done = r_frame_done;
  assign busy       = w_busy;
  assign err        = r_err;

  // Dispatch needs IDLE, capture needs BUSY, accept needs DONE, so the three never collide on one slot.
  always_comb begin
    w_cap  = '0;
    w_busy = 1'b0;
    w_err  = 1'b0;
    for (int i = 0; i < N_ENGINES; i++) begin
      w_cap[i]    = eng_done[i] && (r_st[i] == BUSY);
      w_busy      = w_busy || (r_st[i] != IDLE);
      w_err       = w_err || (eng_done[i] && !w_cap[i]);
      w_st_nxt[i] = (w_disp && r_dp == PW'(i)) ? BUSY :
                    w_cap[i]                   ? DONE :
                    (w_acc && r_op == PW'(i))  ? IDLE : r_st[i];
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      for (int i = 0; i < N_ENGINES; i++) begin
        r_st[i]    <= IDLE;
        r_depth[i] <= '0;
      end
      r_sof        <= '0;
      r_eol        <= '0;
      r_last       <= '0;
      r_eng_start  <= '0;
      r_dp         <= '0;
      r_op         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_eng_x      <= '0;
      r_eng_y      <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENGINES; i++) begin
        r_st[i] <= w_st_nxt[i];
        if (w_cap[i]) r_depth[i] <= eng_depth[i*DEPTH_W +: DEPTH_W];
      end
      r_eng_start <= '0;
      if (w_disp) begin
        r_eng_start[r_dp] <= 1'b1;
        r_eng_x           <= r_x;
        r_eng_y           <= r_y;
        r_sof[r_dp]       <= (r_x == '0) && (r_y == '0);
        r_eol[r_dp]       <= w_xl;
        r_last[r_dp]      <= w_xl && w_yl;
        r_dp              <= (r_dp == P_LAST) ? '0 : r_dp + 1'b1;
        r_x               <= w_xl ? '0 : r_x + 10'd1;
        r_y               <= !w_xl ? r_y : w_yl ? '0 : r_y + 9'd1;
      end
      if (w_acc) r_op <= (r_op == P_LAST) ? '0 : r_op + 1'b1;
      r_frame_done <= w_acc && r_last[r_op];
      r_err        <= r_err || w_err;
    end
  end

`ifdef PIXEL_SCHED_PERF_EN
  // Dispatch of frame k+1 can begin before frame k drains, so start stamps are kept per frame parity.
  logic [31:0] r_cyc, r_stall, r_stall_snap, r_pf, r_ps;
  logic [31:0] r_t0 [2];
  logic        r_dpar, r_opar;

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      r_cyc        <= '0;
      r_stall      <= '0;
      r_stall_snap <= '0;
      r_pf         <= '0;
      r_ps         <= '0;
      r_t0[0]      <= '0;
      r_t0[1]      <= '0;
      r_dpar       <= 1'b0;
      r_opar       <= 1'b0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_disp && r_x == '0 && r_y == '0) r_t0[r_dpar] <= r_cyc + 32'd1;
      if (w_disp && w_xl && w_yl) begin
        r_dpar       <= ~r_dpar;
        r_stall_snap <= r_stall;
        r_stall      <= '0;
      end else if (run && !w_disp) begin
        r_stall <= r_stall + 32'd1;
      end
      if (w_acc && r_last[r_op]) begin
        r_opar <= ~r_opar;
        r_pf   <= r_cyc + 32'd1 - r_t0[r_opar];
        r_ps   <= r_stall_snap;
      end
    end
  end

  assign perf_frame_cycles = r_pf;
  assign perf_stall_cycles = r_ps;
`endif
endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: directed bench with engine model and raster-order scoreboard for pixel_scheduler.
module tb_pixel_scheduler;
  localparam int N = 4, XS = 8, YS = 2, DW = 8;

  logic            clk = 1'b0, rst_n = 1'b0, run = 1'b0, pix_ready = 1'b0;
  logic [N-1:0]    eng_start, eng_done, inj = '0, mdone = '0;
  logic [9:0]      eng_x;
  logic [8:0]      eng_y;
  logic [N*DW-1:0] eng_depth = '0;
  logic [DW-1:0]   pix_depth, d0;
  logic            pix_valid, pix_sof, pix_eol, frame_done, busy, err, e0_seen = 1'b0;
`ifdef PIXEL_SCHED_PERF_EN
  logic [31:0]     perf_frame_cycles, perf_stall_cycles;
`endif
  int n_cmp = 0, n_bad = 0, n_start = 0, n_out = 0, n_sof = 0, n_eol = 0, n_fd = 0;
  int xm = 0, ym = 0, dpm = 0, n_cyc = 0, ts0 = 0, tsl = 0, tfd = 0, s = 0;
  int dly [N];
  int cnt [N];
  logic [10:0] q [$];

  assign eng_done = mdone | inj;
  always #5 clk = ~clk;

  pixel_scheduler #(.N_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .DEPTH_W(DW)) dut (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .run(run),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_depth(eng_depth),
    .pix_depth(pix_depth), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .busy(busy), .err(err)
`ifdef PIXEL_SCHED_PERF_EN
    , .perf_frame_cycles(perf_frame_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: handshake snapshot before the edge, then score outputs and step the engine model.
  task automatic cyc();
    logic acc, efd;
    logic [9:0] obs;
    logic [10:0] e;
    acc = pix_valid && pix_ready;
    obs = {pix_sof, pix_eol, pix_depth};
    @(negedge clk);
    n_cyc++;
    efd = 1'b0;
    if (acc) begin
      n_out++;
      n_sof += 32'(obs[9]);
      n_eol += 32'(obs[8]);
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pix_out", 32'(obs), 32'(e[9:0]));
        efd = e[10];
      end
    end
    if (frame_done || efd) begin
      chk("frame_done", 32'(frame_done), 32'(efd));
      n_fd += 32'(frame_done);
      tfd = n_cyc;
    end
    mdone = '0;
    for (int i = 0; i < N; i++) if (cnt[i] > 0) begin
      cnt[i]--;
      if (cnt[i] == 0) begin
        mdone[i] = 1'b1;
        if (i == 0) e0_seen = 1'b1;
      end
    end
    if (eng_start != '0) begin
      n_start++;
      chk("start_onehot", 32'(eng_start), 32'(1) << dpm);
      chk("start_x", 32'(eng_x), 32'(xm));
      chk("start_y", 32'(eng_y), 32'(ym));
      for (int i = 0; i < N; i++) if (eng_start[i]) begin
        cnt[i] = dly[i];
        eng_depth[i*DW +: DW] = DW'(32'(eng_x) + 8 * 32'(eng_y));
      end
      if (xm == 0 && ym == 0) ts0 = n_cyc;
      if (xm == XS-1 && ym == YS-1) tsl = n_cyc;
      q.push_back({xm == XS-1 && ym == YS-1, xm == 0 && ym == 0, xm == XS-1, DW'(xm + 8 * ym)});
      dpm = (dpm + 1) % N;
      if (xm == XS-1) begin
        xm = 0;
        ym = (ym == YS-1) ? 0 : ym + 1;
      end else xm++;
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 && (busy || q.size() != 0); k++) cyc();
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({eng_start, pix_valid, pix_sof, pix_eol, frame_done, busy, err}), 32'd0);
    chk({tag, "_xy"}, 32'({eng_x, eng_y}), 32'd0);
    chk({tag, "_depth"}, 32'(pix_depth), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      dly[i] = 5;
      cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1; pix_ready = 1'b1; run = 1'b1;
    // full 8x2 frame, uniform engine latency
    for (int k = 0; k < 300 && n_start < 16; k++) cyc();
    run = 1'b0;
    chk("t1_starts", 32'(n_start), 32'd16);
    drain("t1_drain");
    chk("t1_out", 32'(n_out), 32'd16);
    chk("t1_sof", 32'(n_sof), 32'd1);
    chk("t1_eol", 32'(n_eol), 32'd2);
    chk("t1_fd", 32'(n_fd), 32'd1);
`ifdef PIXEL_SCHED_PERF_EN
    chk("perf_frame", perf_frame_cycles, 32'(tfd - ts0));
    chk("perf_stall", perf_stall_cycles, 32'(tsl - ts0 + 1 - 16));
    chk("perf_stall_nz", 32'(perf_stall_cycles != 0), 32'd1);
`endif
    // out-of-order completion: engine 3 first, engine 0 last
    dly = '{8, 6, 4, 2};
    e0_seen = 1'b0;
    run = 1'b1;
    for (int k = 0; k < 50 && n_start < 20; k++) cyc();
    run = 1'b0;
    chk("t2_starts", 32'(n_start), 32'd20);
    for (int k = 0; k < 40 && !pix_valid; k++) cyc();
    chk("t2_valid", 32'(pix_valid), 32'd1);
    chk("t2_e0_first", 32'(e0_seen), 32'd1);
    drain("t2_drain");
    chk("t2_out", 32'(n_out), 32'd20);
    // backpressure with every slot DONE
    dly = '{2, 2, 2, 2};
    pix_ready = 1'b0; run = 1'b1;
    for (int k = 0; k < 30 && n_start < 24; k++) cyc();
    repeat (6) cyc();
    chk("t3_valid", 32'(pix_valid), 32'd1);
    chk("t3_head", 32'(pix_depth), 32'(q[0][DW-1:0]));
    d0 = pix_depth;
    s = n_start;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t3_hold", 32'({pix_valid, pix_depth}), 32'({1'b1, d0}));
    end
    chk("t3_no_start", 32'(n_start), 32'(s));
    run = 1'b0; pix_ready = 1'b1;
    s = n_out;
    repeat (4) cyc();
    chk("t3_burst", 32'(n_out - s), 32'd4);
    drain("t3_drain");
    // pause and resume dispatch
    run = 1'b1;
    for (int k = 0; k < 60 && n_start < 30; k++) cyc();
    run = 1'b0;
    chk("t4_starts", 32'(n_start), 32'd30);
    repeat (20) cyc();
    chk("t4_paused", 32'(n_start), 32'd30);
    run = 1'b1;
    for (int k = 0; k < 20 && n_start < 31; k++) cyc();
    run = 1'b0;
    chk("t4_resume_x", 32'(eng_x), 32'd6);
    chk("t4_resume_y", 32'(eng_y), 32'd1);
    drain("t4_drain");
    chk("t4_out", 32'(n_out), 32'd31);
    // stray done on an idle slot
    chk("t5_err0", 32'(err), 32'd0);
    inj = 4'b0100;
    cyc();
    inj = '0;
    cyc();
    chk("t5_err1", 32'(err), 32'd1);
    run = 1'b1;
    for (int k = 0; k < 60 && n_start < 36; k++) cyc();
    run = 1'b0;
    drain("t5_drain");
    chk("t5_out", 32'(n_out), 32'd36);
    chk("t5_err_sticky", 32'(err), 32'd1);
    // asynchronous reset mid-frame
    run = 1'b1;
    for (int k = 0; k < 20 && n_start < 38; k++) cyc();
    rst_n = 1'b0;
    #1;
    chk_zero("t5_async_rst");
    q.delete();
    xm = 0; ym = 0; dpm = 0; mdone = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s = n_start;
    for (int k = 0; k < 20 && n_start == s; k++) cyc();
    run = 1'b0;
    chk("t5_first_start", 32'(eng_start), 32'd1);
    chk("t5_first_xy", 32'({eng_x, eng_y}), 32'd0);
    drain("t5_drain2");
    chk("t5_err_clr", 32'(err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
